// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one fixed-latency memory port between I-cache and D-cache refill engines
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int MEM_LAT = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              ic_done,
    output logic              dc_done,
    output logic [LINE_W-1:0] rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state, state_nx;
    logic       last_grant;
    logic [3:0] lat_cnt;
    logic       any_req;
    logic       pick_data;

    assign any_req   = ic_req | dc_req;
    // data wins when it is alone, or on a tie when instr was served last
    assign pick_data = dc_req & (~ic_req | ~last_grant);

    assign mem_req = state == ISSUE;
    assign busy    = state != IDLE;
    assign ic_done = (state == RESP) & ~grant_data;
    assign dc_done = (state == RESP) & grant_data;

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state: leave WAIT on the cycle the latency counter reaches zero
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any_req ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (lat_cnt == 4'd0) ? RESP : WAIT;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // latch winner command, count latency, capture read line, track last grant
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_data <= 1'b0;
            last_grant <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            rd_data    <= '0;
            lat_cnt    <= 4'd0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_data <= pick_data;
                mem_addr   <= pick_data ? dc_addr : ic_addr;
                mem_we     <= pick_data & dc_we;
                mem_wdata  <= pick_data ? dc_wdata : '0;
            end
            if (state == ISSUE)
                lat_cnt <= 4'(MEM_LAT - 1);
            if (state == WAIT && lat_cnt != 4'd0)
                lat_cnt <= lat_cnt - 4'd1;
            if (state == WAIT && lat_cnt == 4'd0 && !mem_we)
                rd_data <= mem_rdata;
            if (state == RESP)
                last_grant <= grant_data;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus, transaction-level model compared every cycle, plus literal expectations
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int L  = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ic_req, dc_req, dc_we;
    logic [AW-1:0] ic_addr, dc_addr;
    logic [LW-1:0] dc_wdata, mem_rdata;
    logic          ic_done, dc_done, mem_req, mem_we, busy, grant_data;
    logic [LW-1:0] rd_data, mem_wdata;
    logic [AW-1:0] mem_addr;

    logic          ic_req_1;
    logic [AW-1:0] ic_addr_1;
    logic [LW-1:0] mem_rdata_1;
    logic          ic_done_1, dc_done_1, mem_req_1, mem_we_1, busy_1, grant_data_1;
    logic [LW-1:0] rd_data_1, mem_wdata_1;
    logic [AW-1:0] mem_addr_1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(L)) uu (
        .clk(clk), .reset(reset), .ic_req(ic_req), .ic_addr(ic_addr),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .ic_done(ic_done), .dc_done(dc_done), .rd_data(rd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant_data(grant_data));

    mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset), .ic_req(ic_req_1), .ic_addr(ic_addr_1),
        .dc_req(1'b0), .dc_we(1'b0), .dc_addr('0), .dc_wdata('0),
        .ic_done(ic_done_1), .dc_done(dc_done_1), .rd_data(rd_data_1),
        .mem_req(mem_req_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_rdata(mem_rdata_1), .busy(busy_1), .grant_data(grant_data_1));

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Model: a transaction occupies k = 1..L+2 cycles after its request was sampled;
    // mem_req at k=1, memory answers at k=L+1, done at k=L+2.
    bit            chk_en = 0;
    bit            m_act = 0;
    int            m_k = 0;
    logic          m_gd = 0, m_last = 0, m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wdata = '0, m_rd = '0, mem_line = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_act);
            chk("mem_req", mem_req, m_act && m_k == 1);
            chk("ic_done", ic_done, m_act && m_k == L + 2 && !m_gd);
            chk("dc_done", dc_done, m_act && m_k == L + 2 && m_gd);
            chk("grant_data", grant_data, m_gd);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("rd_data", rd_data, m_rd);
        end
        mem_rdata = (m_act && m_k == L + 1) ? mem_line : {4{$urandom}};
        if (reset) begin
            m_act = 0; m_k = 0; m_gd = 0; m_last = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_rd = '0;
        end else if (m_act) begin
            if (m_k == L + 1 && !m_we) m_rd = mem_line;
            if (m_k == L + 2) begin
                m_act = 0;
                m_last = m_gd;
            end else m_k++;
        end else if (ic_req || dc_req) begin
            m_gd = dc_req && (!ic_req || !m_last);
            m_addr = m_gd ? dc_addr : ic_addr;
            m_we = m_gd && dc_we;
            m_wdata = m_gd ? dc_wdata : '0;
            m_act = 1;
            m_k = 1;
        end
    end

    initial begin
        int mr;
        ic_req = 0; dc_req = 0; dc_we = 0; ic_addr = '0; dc_addr = '0; dc_wdata = '0;
        ic_req_1 = 0; ic_addr_1 = '0; mem_rdata_1 = {4{32'hDEADBEEF}};
        run(2);
        reset = 0;
        chk_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_grant", grant_data, 0);
        chk("rst1_busy", busy_1, 0);
        chk("rst1_dc_done", dc_done_1, 0);
        chk("rst1_mem_we", mem_we_1, 0);
        chk("rst1_mem_addr", mem_addr_1, 0);
        chk("rst1_mem_wdata", mem_wdata_1, 0);
        chk("rst1_grant", grant_data_1, 0);

        // tie out of reset: data, instr, data, instr
        mem_line = {16{8'h3C}};
        ic_addr = 32'h100; dc_addr = 32'h200; ic_req = 1; dc_req = 1;
        for (int c = 0; c < 32; c++) begin
            chk("tie_mem_req", mem_req, c % 8 == 1);
            chk("tie_dc_done", dc_done, c == 7 || c == 23);
            chk("tie_ic_done", ic_done, c == 15 || c == 31);
            if (c == 1) chk("tie_first_grant", grant_data, 1);
            if (c < 31) tick();
        end
        ic_req = 0; dc_req = 0;
        run(3);

        // single instruction read
        mem_line = {16{8'hA5}};
        ic_addr = 32'h1000; ic_req = 1;
        tick();
        chk("rd_mem_req", mem_req, 1);
        chk("rd_mem_addr", mem_addr, 32'h1000);
        chk("rd_mem_we", mem_we, 0);
        run(6);
        chk("rd_ic_done", ic_done, 1);
        chk("rd_dc_done", dc_done, 0);
        chk("rd_line", rd_data, {16{8'hA5}});
        ic_req = 0;
        run(3);

        // data write-back leaves rd_data alone
        mem_line = {16{8'h77}};
        dc_we = 1; dc_addr = 32'h2040; dc_wdata = {8{16'h1234}}; dc_req = 1;
        tick();
        chk("wb_mem_req", mem_req, 1);
        chk("wb_mem_we", mem_we, 1);
        chk("wb_mem_addr", mem_addr, 32'h2040);
        chk("wb_mem_wdata", mem_wdata, {8{16'h1234}});
        run(6);
        chk("wb_dc_done", dc_done, 1);
        chk("wb_rd_hold", rd_data, {16{8'hA5}});
        dc_req = 0; dc_we = 0;
        run(3);

        // data request arriving during an instruction WAIT
        mem_line = {16{8'h5A}};
        ic_addr = 32'h3000; dc_addr = 32'h4000; ic_req = 1;
        mr = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 3) dc_req = 1;
            if (c >= 2 && c <= 8) mr += int'(mem_req);
            if (c == 7) begin
                chk("pend_ic_done", ic_done, 1);
                ic_req = 0;
            end
            if (c == 9) begin
                chk("pend_mem_req", mem_req, 1);
                chk("pend_grant", grant_data, 1);
                chk("pend_addr", mem_addr, 32'h4000);
            end
            if (c == 15) begin
                chk("pend_dc_done", dc_done, 1);
                chk("pend_line", rd_data, {16{8'h5A}});
                dc_req = 0;
            end
        end
        chk("pend_no_extra_req", mr, 0);
        run(3);

        // reset during a read
        mem_line = {16{8'hC3}};
        ic_addr = 32'h5000; ic_req = 1;
        run(3);
        reset = 1; ic_req = 0;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_mem_req", mem_req, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_rd_data", rd_data, 0);
        chk("abort_ic_done", ic_done, 0);
        reset = 0;
        run(8);
        mem_line = {16{8'h96}};
        ic_addr = 32'h6000; ic_req = 1;
        run(7);
        chk("fresh_ic_done", ic_done, 1);
        chk("fresh_line", rd_data, {16{8'h96}});
        ic_req = 0;
        run(3);

        // MEM_LAT=1 instance: done 3 cycles after the request
        ic_addr_1 = 32'h7000; ic_req_1 = 1;
        tick();
        chk("lat1_mem_req", mem_req_1, 1);
        tick();
        mem_rdata_1 = {16{8'hE7}};
        chk("lat1_early_done", ic_done_1, 0);
        tick();
        mem_rdata_1 = {4{32'hDEADBEEF}};
        chk("lat1_ic_done", ic_done_1, 1);
        chk("lat1_line", rd_data_1, {16{8'hE7}});
        ic_req_1 = 0;
        tick();
        chk("lat1_done_pulse", ic_done_1, 0);
        chk("lat1_idle", busy_1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single main-memory port between the instruction-cache and data-cache miss/refill engines. Whenever the instruction-cache or data-cache refill path would stall the pipeline, its request lands here. The block grants one requester at a time, issues a one-cycle command to the fixed-latency memory, counts the latency, captures the returned line and signals completion to the winner. Ties are resolved round-robin so neither cache starves.

## Interface
- ADDR_W, 32, address width (line-aligned byte address)
- LINE_W, 128, cache line width in bits
- MEM_LAT, 5, memory read/write latency in cycles from mem_req to data valid; legal range 1..15

- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- ic_req  in  1  instruction-cache line read request, held until ic_done
- ic_addr  in  ADDR_W  instruction line address, stable while ic_req=1
- dc_req  in  1  data-cache request, held until dc_done
- dc_we  in  1  1 = line write-back, 0 = line fill; stable while dc_req=1
- dc_addr  in  ADDR_W  data line address
- dc_wdata  in  LINE_W  write-back line
- ic_done  out  1  one-cycle completion pulse to instruction cache
- dc_done  out  1  one-cycle completion pulse to data cache
- rd_data  out  LINE_W  returned line, valid while either done is high
- mem_req  out  1  one-cycle memory command strobe
- mem_we  out  1  write qualifier for mem_req
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  LINE_W  command write data
- mem_rdata  in  LINE_W  memory read data, valid exactly MEM_LAT cycles after mem_req
- busy  out  1  1 in any state other than IDLE
- grant_data  out  1  1 while the current transaction belongs to the data cache

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE → ISSUE when ic_req or dc_req is 1. The winner is latched into grant_data together with its address, we and wdata.
  - Only one requester active: it wins.
  - Both active: the side not served last wins. last_grant register: 0 = instr, 1 = data.
  - After reset, last_grant = instr, so the first tie goes to the data cache.
- ISSUE: mem_req=1 for exactly one cycle with the latched mem_addr/mem_we/mem_wdata. Load lat_cnt = MEM_LAT-1. Go to WAIT.
- WAIT: decrement lat_cnt each cycle. In the cycle lat_cnt==0:
  - for a read, register mem_rdata into rd_data;
  - go to RESP.
- RESP: assert ic_done or dc_done per grant_data. Update last_grant. Go to IDLE.
- Write transactions do not update rd_data; it holds its previous value.
- Requester rule: deassert req at the clock edge where done=1 is sampled. A req still high in IDLE is treated as a new request.
- Request inputs are ignored outside IDLE. A request arriving mid-transaction waits.
- mem_addr/mem_we/mem_wdata hold the latched values from ISSUE through RESP. They are 0 only after reset.
- The arbiter makes no dc_we/ic ordering guarantee beyond round-robin. Coherence between a pending write-back and an instruction fill of the same line is the caches' responsibility.

## Timing
- Reset values: state=IDLE, ic_done=dc_done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_data=0, busy=0, grant_data=0, last_grant=instr, lat_cnt=0.
- Reset while busy aborts the transaction at the next edge. No done is issued. A memory response in flight is ignored.
- Request sampled in IDLE at cycle 0 produces:
  - ISSUE / mem_req at cycle 1;
  - WAIT in cycles 2..MEM_LAT+1;
  - done at cycle MEM_LAT+2.
- Total request-to-done latency = MEM_LAT+2 cycles (7 for default).
- Back-to-back throughput: one transaction per MEM_LAT+3 cycles, because RESP is followed by one IDLE cycle.
- busy=1 from ISSUE through RESP inclusive. grant_data is valid in the same window.
- done is never high for more than one cycle. ic_done and dc_done are never high together.

## Test plan
- Single ic_req=1, ic_addr=0x1000, memory returns 0xA5…A5 → mem_req at cycle 1 with addr 0x1000 and we=0; ic_done=1 and rd_data=0xA5…A5 at cycle 7; dc_done stays 0.
- Out of reset, ic_req and dc_req both asserted at cycle 0, both held and re-asserted after each done → order data, instr, data, instr; mem_req pulses every 8 cycles.
- dc_req with dc_we=1, dc_wdata=0x1234…, addr 0x2040 → mem_req, mem_we=1, mem_wdata=0x1234… at cycle 1; dc_done at cycle 7; rd_data unchanged from its prior value.
- dc_req asserted during an instruction WAIT → no second mem_req until the instruction transaction completes; data is then served with mem_req one cycle after the IDLE cycle.
- reset pulsed at cycle 3 of a read → all outputs return to reset values next cycle; no done pulse; a fresh request afterward completes normally in 7 cycles.
- MEM_LAT=1 build → request-to-done latency of 3 cycles; rd_data captured correctly.
